// File: rtl/gpu_pkg.sv
// rtl/gpu_pkg.sv - shared widths and types for the work dispatcher
package gpu_pkg;

  localparam int PC_W       = 16;
  localparam int QID_W      = 4;
  localparam int NUM_QUEUES = 1 << QID_W;

  typedef logic [PC_W-1:0]  pc_t;
  typedef logic [QID_W-1:0] qid_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin arbiter with registered rotating pointer
// Ports:
//   clk, rst_n   clock, synchronous active-low reset (pointer -> 0)
//   req[N]       requesters
//   advance      allow the pointer to move past the current winner
//   grant[N]     one-hot winner (combinational)
//   grant_idx    binary index of the winner
//   grant_valid  some requester won
module rr_arbiter #(
  parameter int N = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req,
  input  logic          advance,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx,
  output logic          grant_valid
);

  logic [IW-1:0] ptr;
  logic [IW-1:0] idx;

  // Scan starting at the pointer; first requester found wins.
  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    idx         = '0;
    for (int k = 0; k < N; k++) begin
      idx = IW'((int'(ptr) + k) % N);
      if (!grant_valid && req[idx]) begin
        grant[idx]  = 1'b1;
        grant_idx   = idx;
        grant_valid = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (advance && grant_valid) begin
      if (int'(grant_idx) == N - 1) ptr <= '0;
      else                          ptr <= grant_idx + IW'(1);
    end
  end

endmodule

// File: rtl/work_dispatcher.sv
// rtl/work_dispatcher.sv - per-queue PC FIFOs with round-robin push/pop arbitration
// Ports:
//   clk, rst_n    clock, synchronous active-low reset
//   push_req      per-core push request; push_qid / push_pc carry queue and PC
//   push_ack      1-cycle pulse when a core's push was accepted
//   pop_req       per-core work request, held until granted
//   pop_grant     1-cycle pulse: new_pc slice for that core is valid
//   new_pc        per-core granted PC, held until the next grant
//   queue_empty   per-queue empty flag
//   all_idle      all queues empty and no core requesting work
module work_dispatcher
  import gpu_pkg::*;
#(
  parameter int NUM_CORES = 4,
  parameter int DEPTH     = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_CORES-1:0]        push_req,
  input  logic [QID_W*NUM_CORES-1:0]  push_qid,
  input  logic [PC_W*NUM_CORES-1:0]   push_pc,
  output logic [NUM_CORES-1:0]        push_ack,
  input  logic [NUM_CORES-1:0]        pop_req,
  output logic [NUM_CORES-1:0]        pop_grant,
  output logic [PC_W*NUM_CORES-1:0]   new_pc,
  output logic [NUM_QUEUES-1:0]       queue_empty,
  output logic                        all_idle
);

  localparam int PW  = $clog2(DEPTH);
  localparam int CW  = PW + 1;
  localparam int CIW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  typedef logic [PW-1:0] ptr_t;
  typedef logic [CW-1:0] cnt_t;

  localparam cnt_t FULL = cnt_t'(DEPTH);

  pc_t  mem      [NUM_QUEUES][DEPTH];
  ptr_t q_head   [NUM_QUEUES];
  ptr_t q_tail   [NUM_QUEUES];
  cnt_t q_count  [NUM_QUEUES];

  qid_t core_qid [NUM_CORES];
  pc_t  core_pc  [NUM_CORES];
  pc_t  new_pc_r [NUM_CORES];

  for (genvar g = 0; g < NUM_CORES; g++) begin : g_core
    assign core_qid[g]               = push_qid[g*QID_W +: QID_W];
    assign core_pc[g]                = push_pc[g*PC_W +: PC_W];
    assign new_pc[g*PC_W +: PC_W]    = new_pc_r[g];
  end

  for (genvar q = 0; q < NUM_QUEUES; q++) begin : g_empty
    assign queue_empty[q] = (q_count[q] == '0);
  end

  assign all_idle = (&queue_empty) & ~(|pop_req);

  // ---------------- push path ----------------
  // The ~push_ack term hides a request still held during its ack cycle.
  logic [NUM_CORES-1:0] push_elig;
  logic [NUM_CORES-1:0] push_gnt;
  logic [CIW-1:0]       push_win;
  logic                 push_do;
  qid_t                 wr_qid;
  pc_t                  wr_pc;

  always_comb begin
    push_elig = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      push_elig[i] = push_req[i] & ~push_ack[i] & (q_count[core_qid[i]] != FULL);
    end
  end

  rr_arbiter #(.N(NUM_CORES)) u_push_arb (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (push_elig),
    .advance     (1'b1),
    .grant       (push_gnt),
    .grant_idx   (push_win),
    .grant_valid (push_do)
  );

  assign wr_qid = core_qid[push_win];
  assign wr_pc  = core_pc[push_win];

  // ---------------- pop path ----------------
  logic [NUM_CORES-1:0] pop_cand;
  logic [NUM_CORES-1:0] pop_arb_gnt;
  logic [NUM_CORES-1:0] pop_gnt;
  logic [CIW-1:0]       pop_win;
  logic                 pop_arb_valid;
  logic                 pop_do;
  logic                 src_valid;
  qid_t                 src_q;
  pc_t                  rd_pc;

  // Lowest-numbered non-empty queue supplies work; scan high to low so the
  // last hit is the lowest index.
  always_comb begin
    src_valid = 1'b0;
    src_q     = '0;
    for (int q = NUM_QUEUES - 1; q >= 0; q--) begin
      if (q_count[q] != '0) begin
        src_valid = 1'b1;
        src_q     = qid_t'(q);
      end
    end
  end

  assign pop_cand = pop_req & ~pop_grant;

  // With no work available the arbiter must not rotate.
  rr_arbiter #(.N(NUM_CORES)) u_pop_arb (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (pop_cand),
    .advance     (src_valid),
    .grant       (pop_arb_gnt),
    .grant_idx   (pop_win),
    .grant_valid (pop_arb_valid)
  );

  assign pop_do  = src_valid & pop_arb_valid;
  assign pop_gnt = pop_arb_gnt & {NUM_CORES{src_valid}};
  assign rd_pc   = mem[src_q][q_head[src_q]];

  // ---------------- state ----------------
  always_ff @(posedge clk) begin
    if (rst_n && push_do) begin
      mem[wr_qid][q_tail[wr_qid]] <= wr_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      push_ack  <= '0;
      pop_grant <= '0;
      for (int i = 0; i < NUM_CORES; i++) new_pc_r[i] <= '0;
      for (int q = 0; q < NUM_QUEUES; q++) begin
        q_head[q]  <= '0;
        q_tail[q]  <= '0;
        q_count[q] <= '0;
      end
    end else begin
      push_ack  <= push_gnt;
      pop_grant <= pop_gnt;
      if (pop_do) new_pc_r[pop_win] <= rd_pc;
      for (int q = 0; q < NUM_QUEUES; q++) begin
        if (push_do && wr_qid == qid_t'(q)) q_tail[q] <= q_tail[q] + ptr_t'(1);
        if (pop_do && src_q == qid_t'(q))   q_head[q] <= q_head[q] + ptr_t'(1);
        // Push and pop on the same queue in one cycle leave the count unchanged.
        if ((push_do && wr_qid == qid_t'(q)) && !(pop_do && src_q == qid_t'(q)))
          q_count[q] <= q_count[q] + cnt_t'(1);
        else if (!(push_do && wr_qid == qid_t'(q)) && (pop_do && src_q == qid_t'(q)))
          q_count[q] <= q_count[q] - cnt_t'(1);
      end
    end
  end

endmodule

// File: tb/tb_work_dispatcher.sv
// tb/tb_work_dispatcher.sv - directed self-checking bench for work_dispatcher
module tb_work_dispatcher;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  push_req;
  logic [15:0] push_qid;
  logic [63:0] push_pc;
  logic [3:0]  push_ack;
  logic [3:0]  pop_req;
  logic [3:0]  pop_grant;
  logic [63:0] new_pc;
  logic [15:0] queue_empty;
  logic        all_idle;

  int n_chk  = 0;
  int n_pass = 0;

  work_dispatcher #(.NUM_CORES(4), .DEPTH(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_req    (push_req),
    .push_qid    (push_qid),
    .push_pc     (push_pc),
    .push_ack    (push_ack),
    .pop_req     (pop_req),
    .pop_grant   (pop_grant),
    .new_pc      (new_pc),
    .queue_empty (queue_empty),
    .all_idle    (all_idle)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [15:0] pc_of(input int c);
    return new_pc[c*16 +: 16];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_push(input int c, input logic [3:0] q, input logic [15:0] pc);
    push_qid[c*4 +: 4]  = q;
    push_pc[c*16 +: 16] = pc;
    push_req[c]         = 1'b1;
  endtask

  task automatic push1(input string tag, input int c, input logic [3:0] q, input logic [15:0] pc);
    set_push(c, q, pc);
    step();
    check({tag, "_ack"}, push_ack, 64'(4'b0001 << c));
    push_req[c] = 1'b0;
    step();
  endtask

  task automatic pop1(input string tag, input int c, input logic [15:0] exp_pc);
    pop_req[c] = 1'b1;
    step();
    check({tag, "_grant"}, pop_grant, 64'(4'b0001 << c));
    check({tag, "_pc"}, pc_of(c), exp_pc);
    pop_req[c] = 1'b0;
    step();
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    push_req = '0;
    pop_req  = '0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    // 1: reset with every request asserted
    rst_n    = 1'b0;
    push_req = 4'hF;
    pop_req  = 4'hF;
    push_qid = 16'h3210;
    push_pc  = 64'h1111_2222_3333_4444;
    for (int k = 0; k < 3; k++) begin
      step();
      check("rst_push_ack", push_ack, 4'h0);
      check("rst_pop_grant", pop_grant, 4'h0);
      check("rst_new_pc", new_pc, 64'h0);
      check("rst_qempty", queue_empty, 16'hFFFF);
    end
    rst_n    = 1'b1;
    push_req = '0;
    pop_req  = '0;
    step();
    check("post_rst_qempty", queue_empty, 16'hFFFF);
    check("post_rst_ack", push_ack, 4'h0);
    check("post_rst_idle", all_idle, 1'b1);

    // 2: push then pop one entry
    set_push(0, 4'd3, 16'h0040);
    step();
    check("t2_ack", push_ack, 4'b0001);
    check("t2_q3_busy", queue_empty[3], 1'b0);
    push_req[0] = 1'b0;
    pop_req[1]  = 1'b1;
    step();
    check("t2_grant", pop_grant, 4'b0010);
    check("t2_pc", pc_of(1), 16'h0040);
    check("t2_q3_empty", queue_empty[3], 1'b1);
    check("t2_ack_clear", push_ack, 4'b0000);
    pop_req[1] = 1'b0;
    step();
    check("t2_grant_pulse", pop_grant, 4'b0000);
    check("t2_pc_held", pc_of(1), 16'h0040);

    // 3: lower queue number wins
    push1("t3_push_q5", 0, 4'd5, 16'h0100);
    push1("t3_push_q2", 0, 4'd2, 16'h0200);
    check("t3_qempty", queue_empty, 16'hFFDB);
    pop1("t3_pop_first", 2, 16'h0200);
    pop1("t3_pop_second", 2, 16'h0100);
    check("t3_qempty_end", queue_empty, 16'hFFFF);

    // 4: fairness, all cores push to q0 together
    do_reset();
    for (int c = 0; c < 4; c++) set_push(c, 4'd0, 16'h00A0 + 16'(c));
    for (int k = 0; k < 4; k++) begin
      step();
      check($sformatf("t4_ack%0d", k), push_ack, 64'(4'b0001 << k));
      push_req[k] = 1'b0;
    end
    step();
    for (int k = 0; k < 4; k++) pop1($sformatf("t4_pop%0d", k), 0, 16'h00A0 + 16'(k));

    // 5: full queue
    for (int k = 0; k < 8; k++) push1($sformatf("t5_fill%0d", k), 0, 4'd7, 16'h0700 + 16'(k));
    check("t5_q7_busy", queue_empty[7], 1'b0);
    set_push(0, 4'd7, 16'h07FF);
    step();
    check("t5_stall_a", push_ack, 4'b0000);
    step();
    check("t5_stall_b", push_ack, 4'b0000);
    pop_req[1] = 1'b1;
    step();
    check("t5_pop_grant", pop_grant, 4'b0010);
    check("t5_pop_pc", pc_of(1), 16'h0700);
    check("t5_full_refused", push_ack, 4'b0000);
    pop_req[1] = 1'b0;
    step();
    check("t5_ninth_ack", push_ack, 4'b0001);
    push_req[0] = 1'b0;
    step();
    for (int k = 1; k < 8; k++) pop1($sformatf("t5_drain%0d", k), 1, 16'h0700 + 16'(k));
    pop1("t5_drain_last", 1, 16'h07FF);
    check("t5_q7_empty", queue_empty[7], 1'b1);

    // 6: held requests with no work, then two entries
    do_reset();
    pop_req = 4'hF;
    for (int k = 0; k < 3; k++) begin
      step();
      check("t6_no_grant", pop_grant, 4'h0);
      check("t6_not_idle", all_idle, 1'b0);
    end
    set_push(0, 4'd1, 16'h00B0);
    set_push(1, 4'd1, 16'h00B1);
    step();
    check("t6_ack0", push_ack, 4'b0001);
    check("t6_no_bypass", pop_grant, 4'b0000);
    push_req[0] = 1'b0;
    step();
    check("t6_ack1", push_ack, 4'b0010);
    check("t6_grant0", pop_grant, 4'b0001);
    check("t6_pc0", pc_of(0), 16'h00B0);
    push_req[1] = 1'b0;
    pop_req[0]  = 1'b0;
    step();
    check("t6_grant1", pop_grant, 4'b0010);
    check("t6_pc1", pc_of(1), 16'h00B1);
    check("t6_pc0_held", pc_of(0), 16'h00B0);
    pop_req[1] = 1'b0;
    step();
    check("t6_no_more_a", pop_grant, 4'b0000);
    step();
    check("t6_no_more_b", pop_grant, 4'b0000);
    check("t6_qempty", queue_empty, 16'hFFFF);
    check("t6_busy_reqs", all_idle, 1'b0);
    pop_req = '0;
    #1;
    check("t6_idle", all_idle, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
